sounder_rx_capture: RTL and testbench

Timed capture framer for the channel-sounder receive path. It sits directly downstream of the sounder RX NoC shell's input data port on `axis_data_clk`. It consumes the timestamped 32-bit sample stream, waits for a programmed start time, and then emits exactly `cfg_num_periods` packets of `cfg_period_len` samples each. Each output packet carries an exact timestamp, and the packets feed the shell's output data port.

---
 rtl/sounder_rx_pkg.sv | 25 ++
 rtl/sounder_rx_skid.sv | 59 +++++
 rtl/sounder_rx_capture.sv | 254 +++++++++++++++++++++++++
 tb/tb_sounder_rx_capture.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sounder_rx_pkg.sv
// Shared types and constants for the channel-sounder receive capture framer.
package sounder_rx_pkg;

    localparam int          TS_W       = 64;
    localparam int          DATA_W     = 32;
    localparam int          LENF_W     = 16;
    localparam logic [15:0] ITEM_BYTES = 16'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [TS_W-1:0]   ts;
        logic              has_time;
        logic [LENF_W-1:0] len;
        logic              eob;
    } out_beat_t;

endpackage

// File: rtl/sounder_rx_skid.sv
// Two-entry AXI-stream skid buffer; output is always driven from a register,
// and the input is ready whenever at least one entry is free.
module sounder_rx_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] ent0_r;
    logic [W-1:0] ent1_r;
    logic [1:0]   cnt_r;
    logic         push_s;
    logic         pop_s;

    assign in_ready  = (cnt_r != 2'd2);
    assign out_valid = (cnt_r != 2'd0);
    assign out_data  = ent0_r;
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Entry storage: ent0 is the head, ent1 only holds data while the head stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_r <= '0;
            ent1_r <= '0;
            cnt_r  <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        ent0_r <= in_data;
                    end else begin
                        ent1_r <= in_data;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    ent0_r <= ent1_r;
                    cnt_r  <= cnt_r - 2'd1;
                end
                // Simultaneous push and pop only happens with exactly one entry held.
                2'b11: begin
                    ent0_r <= in_data;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/sounder_rx_capture.sv
// Timed capture framer: waits for a start time, then cuts the sample stream
// into fixed-length timestamped packets. Define SOUNDER_RX_CAPTURE_LATE_CHECK_EN
// for exact-match start with late detection; otherwise start on time >= start.
module sounder_rx_capture
    import sounder_rx_pkg::*;
#(
    parameter int ITEM_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              axis_data_clk,
    input  logic              axis_data_rst,
    input  logic [63:0]       cfg_start_time,
    input  logic [LEN_W-1:0]  cfg_period_len,
    input  logic [LEN_W-1:0]  cfg_num_periods,
    input  logic              cfg_arm,
    input  logic              cfg_stop,
    output logic [1:0]        status_state,
    output logic              status_late,
    output logic              status_cfg_err,
    input  logic [ITEM_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [63:0]       s_axis_ttimestamp,
    input  logic              s_axis_thas_time,
    input  logic              s_axis_teob,
    output logic [ITEM_W-1:0] m_axis_tdata,
    output logic              m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [63:0]       m_axis_ttimestamp,
    output logic              m_axis_thas_time,
    output logic [15:0]       m_axis_tlength,
    output logic              m_axis_teov,
    output logic              m_axis_teob
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_n_s;
    logic             live_r;
    logic             sop_r;
    logic [TS_W-1:0]  cur_time_r, beat_time_s, base_s, cur_pkt_ts_s, ts_r, start_r, len_ext_s;
    logic [LEN_W-1:0] len_r, num_r, sample_cnt_r, period_cnt_r;
    logic             stop_pend_r, cfg_err_r;
    logic             acc_s, start_hit_s, last_s, final_period_s, end_cond_s;
    logic             cap_beat_s, arm_ok_s, err_set_s;
    logic             skid_ready_s, m_valid_s;
    logic             unused_teob_s;
    out_beat_t        beat_s, obeat_s;

    assign unused_teob_s = s_axis_teob;

    assign s_axis_tready = live_r & ((state_r == ST_IDLE) | skid_ready_s);
    assign acc_s         = s_axis_tvalid & s_axis_tready;
    assign beat_time_s   = (sop_r && s_axis_thas_time) ? s_axis_ttimestamp : cur_time_r;

    assign last_s         = (sample_cnt_r == (len_r - LEN_ONE));
    assign final_period_s = (num_r != '0) && (period_cnt_r == (num_r - LEN_ONE));
    assign end_cond_s     = final_period_s | stop_pend_r | cfg_stop;
    assign len_ext_s      = {{(TS_W-LEN_W){1'b0}}, len_r};
    assign cur_pkt_ts_s   = (state_r == ST_ARMED) ? base_s : ts_r;

`ifdef SOUNDER_RX_CAPTURE_LATE_CHECK_EN
    logic late_r;
    logic late_set_s;
    logic start_late_s;
    assign start_hit_s  = (beat_time_s == start_r);
    assign start_late_s = (beat_time_s > start_r);
    assign base_s       = start_r;
`else
    assign start_hit_s  = (beat_time_s >= start_r);
    assign base_s       = beat_time_s;
`endif

    // Sample-time tracker: cur_time_r always holds the time of the next input beat.
    always_ff @(posedge axis_data_clk) begin
        if (axis_data_rst) begin
            cur_time_r <= '0;
            sop_r      <= 1'b1;
        end else if (acc_s) begin
            cur_time_r <= beat_time_s + 64'd1;
            sop_r      <= s_axis_tlast;
        end
    end

    // State register; live_r holds tready low through reset.
    always_ff @(posedge axis_data_clk) begin
        if (axis_data_rst) begin
            state_r <= ST_IDLE;
            live_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            live_r  <= 1'b1;
        end
    end

    // Next-state logic and per-cycle capture decisions.
    always_comb begin
        state_n_s  = state_r;
        cap_beat_s = 1'b0;
        arm_ok_s   = 1'b0;
        err_set_s  = 1'b0;
`ifdef SOUNDER_RX_CAPTURE_LATE_CHECK_EN
        late_set_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (cfg_arm) begin
                    if (cfg_period_len != '0) begin
                        state_n_s = ST_ARMED;
                        arm_ok_s  = 1'b1;
                    end else begin
                        err_set_s = 1'b1;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (cfg_stop) begin
                    state_n_s = ST_IDLE;
                end else if (acc_s && start_hit_s) begin
                    cap_beat_s = 1'b1;
                    state_n_s  = (last_s && end_cond_s) ? ST_IDLE : ST_CAPTURE;
`ifdef SOUNDER_RX_CAPTURE_LATE_CHECK_EN
                end else if (acc_s && start_late_s) begin
                    late_set_s = 1'b1;
                    state_n_s  = ST_IDLE;
`endif
                end else begin
                    state_n_s = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                // A stop between packets closes the capture without a further packet.
                if (cfg_stop && (sample_cnt_r == '0)) begin
                    state_n_s = ST_FLUSH;
                end else if (acc_s) begin
                    cap_beat_s = 1'b1;
                    state_n_s  = (last_s && end_cond_s) ? ST_IDLE : ST_CAPTURE;
                end else begin
                    state_n_s = ST_CAPTURE;
                end
            end
            ST_FLUSH: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Configuration latch plus sample, period and timestamp counters.
    always_ff @(posedge axis_data_clk) begin
        if (axis_data_rst) begin
            start_r      <= '0;
            len_r        <= '0;
            num_r        <= '0;
            sample_cnt_r <= '0;
            period_cnt_r <= '0;
            ts_r         <= '0;
            stop_pend_r  <= 1'b0;
        end else if (arm_ok_s) begin
            start_r      <= cfg_start_time;
            len_r        <= cfg_period_len;
            num_r        <= cfg_num_periods;
            sample_cnt_r <= '0;
            period_cnt_r <= '0;
            stop_pend_r  <= 1'b0;
        end else begin
            if (cap_beat_s) begin
                if (last_s) begin
                    sample_cnt_r <= '0;
                    period_cnt_r <= period_cnt_r + LEN_ONE;
                    ts_r         <= cur_pkt_ts_s + len_ext_s;
                end else begin
                    sample_cnt_r <= sample_cnt_r + LEN_ONE;
                    ts_r         <= cur_pkt_ts_s;
                end
            end
            if ((state_r == ST_CAPTURE) && cfg_stop) begin
                stop_pend_r <= 1'b1;
            end
        end
    end

    // Sticky configuration-error flag.
    always_ff @(posedge axis_data_clk) begin
        if (axis_data_rst) begin
            cfg_err_r <= 1'b0;
        end else if (err_set_s) begin
            cfg_err_r <= 1'b1;
        end else if (arm_ok_s) begin
            cfg_err_r <= 1'b0;
        end
    end

`ifdef SOUNDER_RX_CAPTURE_LATE_CHECK_EN
    // Sticky late-start flag, cleared by any arm accepted in IDLE.
    always_ff @(posedge axis_data_clk) begin
        if (axis_data_rst) begin
            late_r <= 1'b0;
        end else if (late_set_s) begin
            late_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && cfg_arm) begin
            late_r <= 1'b0;
        end
    end
    assign status_late = late_r;
`else
    assign status_late = 1'b0;
`endif

    // Output beat assembly; timestamp only travels on the first beat of a packet.
    always_comb begin
        beat_s          = '0;
        beat_s.data     = s_axis_tdata;
        beat_s.last     = last_s;
        beat_s.has_time = (sample_cnt_r == '0);
        beat_s.ts       = (sample_cnt_r == '0) ? cur_pkt_ts_s : '0;
        beat_s.len      = len_r * ITEM_BYTES;
        beat_s.eob      = last_s & end_cond_s;
    end

    sounder_rx_skid #(
        .W($bits(out_beat_t))
    ) u_skid (
        .clk       (axis_data_clk),
        .rst       (axis_data_rst),
        .in_data   (beat_s),
        .in_valid  (cap_beat_s),
        .in_ready  (skid_ready_s),
        .out_data  (obeat_s),
        .out_valid (m_valid_s),
        .out_ready (m_axis_tready)
    );

    assign m_axis_tdata      = obeat_s.data;
    assign m_axis_tlast      = obeat_s.last;
    assign m_axis_ttimestamp = obeat_s.ts;
    assign m_axis_thas_time  = obeat_s.has_time;
    assign m_axis_tlength    = obeat_s.len;
    assign m_axis_teob       = obeat_s.eob;
    assign m_axis_tkeep      = m_valid_s;
    assign m_axis_teov       = 1'b0;
    assign m_axis_tvalid     = m_valid_s;

    assign status_state   = state_r;
    assign status_cfg_err = cfg_err_r;

endmodule

// File: tb/tb_sounder_rx_capture.sv
// Directed self-checking bench for sounder_rx_capture.
`timescale 1ns/1ps
module tb_sounder_rx_capture;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [63:0] ts;
        logic        has_time;
        logic [15:0] len;
        logic        eob;
        logic        keep;
        logic        eov;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] cfg_start_time;
    logic [15:0] cfg_period_len;
    logic [15:0] cfg_num_periods;
    logic        cfg_arm;
    logic        cfg_stop;
    logic [1:0]  status_state;
    logic        status_late;
    logic        status_cfg_err;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_ttimestamp;
    logic        s_axis_thas_time;
    logic        s_axis_teob;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_ttimestamp;
    logic        m_axis_thas_time;
    logic [15:0] m_axis_tlength;
    logic        m_axis_teov;
    logic        m_axis_teob;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    stall_cnt = 0;
    int    bp_cnt   = 0;
    bit    bp_en    = 1'b0;
    beat_t got_q[$];
    beat_t exp_q[$];

    always #5 clk = ~clk;

    sounder_rx_capture dut (
        .axis_data_clk     (clk),
        .axis_data_rst     (rst),
        .cfg_start_time    (cfg_start_time),
        .cfg_period_len    (cfg_period_len),
        .cfg_num_periods   (cfg_num_periods),
        .cfg_arm           (cfg_arm),
        .cfg_stop          (cfg_stop),
        .status_state      (status_state),
        .status_late       (status_late),
        .status_cfg_err    (status_cfg_err),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_ttimestamp (s_axis_ttimestamp),
        .s_axis_thas_time  (s_axis_thas_time),
        .s_axis_teob       (s_axis_teob),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tkeep      (m_axis_tkeep),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_ttimestamp (m_axis_ttimestamp),
        .m_axis_thas_time  (m_axis_thas_time),
        .m_axis_tlength    (m_axis_tlength),
        .m_axis_teov       (m_axis_teov),
        .m_axis_teob       (m_axis_teob)
    );

    // Output monitor: records each handshaken beat, timestamp kept only where flagged.
    always @(negedge clk) begin : monitor
        beat_t b;
        if (m_axis_tvalid && m_axis_tready && !rst) begin
            b.data     = m_axis_tdata;
            b.last     = m_axis_tlast;
            b.ts       = m_axis_thas_time ? m_axis_ttimestamp : 64'd0;
            b.has_time = m_axis_thas_time;
            b.len      = m_axis_tlength;
            b.eob      = m_axis_tlast & m_axis_teob;
            b.keep     = m_axis_tkeep;
            b.eov      = m_axis_teov;
            got_q.push_back(b);
        end
        if (bp_en && !s_axis_tready && status_state == 2'd2) begin
            stall_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, need bench completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_en) begin
            bp_cnt++;
            m_axis_tready = (bp_cnt < 4) ? 1'b0 : 1'($urandom_range(0, 1));
        end else begin
            m_axis_tready = 1'b1;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l, input logic [63:0] ts,
                             input logic ht, input logic stp);
        bit done = 1'b0;
        s_axis_tdata      = d;
        s_axis_tlast      = l;
        s_axis_ttimestamp = ts;
        s_axis_thas_time  = ht;
        s_axis_teob       = l;
        s_axis_tvalid     = 1'b1;
        cfg_stop          = stp;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = s_axis_tready;
            tick();
        end
        s_axis_tvalid = 1'b0;
        cfg_stop      = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: s_axis_tready stayed 0, need 1");
        end
    endtask

    task automatic send_pkt(input logic [63:0] ts0, input int n, input int stop_idx);
        for (int i = 0; i < n; i++) begin
            send_beat(32'(i), (i == n - 1), ts0, (i == 0), (i == stop_idx));
        end
    endtask

    task automatic arm(input logic [63:0] st, input logic [15:0] len, input logic [15:0] num);
        cfg_start_time  = st;
        cfg_period_len  = len;
        cfg_num_periods = num;
        cfg_arm         = 1'b1;
        tick();
        cfg_arm = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < 300 && got_q.size() < n; i++) begin
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            tick();
        end
    endtask

    task automatic gen_exp(input int d0, input int len, input int npkt,
                           input logic [63:0] ts0, input logic eob_end);
        exp_q.delete();
        for (int p = 0; p < npkt; p++) begin
            for (int s = 0; s < len; s++) begin
                beat_t b;
                b.data     = 32'(d0 + p * len + s);
                b.last     = (s == len - 1);
                b.has_time = (s == 0);
                b.ts       = (s == 0) ? ts0 + 64'(p * len) : 64'd0;
                b.len      = 16'(len * 4);
                b.eob      = eob_end && (p == npkt - 1) && (s == len - 1);
                b.keep     = 1'b1;
                b.eov      = 1'b0;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (s_axis_tready !== 1'b0) $display("FAIL reset_tready: got %b need 0", s_axis_tready); else n_pass++;
        n_checks++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b need 0", m_axis_tvalid); else n_pass++;
        n_checks++;
        if ({status_state, status_late, status_cfg_err} !== 4'b0000)
            $display("FAIL reset_status: got %b need 0000", {status_state, status_late, status_cfg_err});
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (s_axis_tready !== 1'b1) $display("FAIL release_tready: got %b need 1", s_axis_tready); else n_pass++;
    endtask

    task automatic test_exact_start();
        got_q.delete();
        arm(64'd1000, 16'd8, 16'd2);
        n_checks++;
        if (status_state !== 2'd1) $display("FAIL exact_armed: got %0d need 1", status_state); else n_pass++;
        send_pkt(64'd990, 40, -1);
        drain(16);
        gen_exp(10, 8, 2, 64'd1000, 1'b1);
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL exact_count: got %0d need %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL exact_beat[%0d]: got %h need %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (status_state !== 2'd0) $display("FAIL exact_idle: got %0d need 0", status_state); else n_pass++;
    endtask

    task automatic test_late_start();
        got_q.delete();
        arm(64'd100, 16'd4, 16'd1);
        send_pkt(64'd150, 8, -1);
        drain(4);
`ifdef SOUNDER_RX_CAPTURE_LATE_CHECK_EN
        n_checks++;
        if (status_late !== 1'b1) $display("FAIL late_flag: got %b need 1", status_late); else n_pass++;
        n_checks++;
        if (got_q.size() !== 0) $display("FAIL late_no_output: got %0d beats need 0", got_q.size()); else n_pass++;
`else
        gen_exp(0, 4, 1, 64'd150, 1'b1);
        n_checks++;
        if (status_late !== 1'b0) $display("FAIL late_flag: got %b need 0", status_late); else n_pass++;
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL late_count: got %0d need %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL late_beat[%0d]: got %h need %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
`endif
        n_checks++;
        if (status_state !== 2'd0) $display("FAIL late_idle: got %0d need 0", status_state); else n_pass++;
    endtask

    task automatic test_backpressure();
        got_q.delete();
        arm(64'd2000, 16'd5, 16'd3);
        bp_cnt    = 0;
        stall_cnt = 0;
        bp_en     = 1'b1;
        send_pkt(64'd2000, 20, -1);
        drain(15);
        bp_en = 1'b0;
        tick();
        gen_exp(0, 5, 3, 64'd2000, 1'b1);
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL bp_count: got %0d need %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL bp_beat[%0d]: got %h need %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if ((stall_cnt > 0) !== 1'b1) $display("FAIL bp_tready_stall: got %0d stall cycles need >0", stall_cnt); else n_pass++;
    endtask

    task automatic test_continuous_stop();
        got_q.delete();
        arm(64'd3000, 16'd4, 16'd0);
        send_pkt(64'd3000, 40, 25);
        drain(28);
        gen_exp(0, 4, 7, 64'd3000, 1'b1);
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL cont_count: got %0d need %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL cont_beat[%0d]: got %h need %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (status_state !== 2'd0) $display("FAIL cont_idle: got %0d need 0", status_state); else n_pass++;
    endtask

    task automatic test_flush();
        got_q.delete();
        arm(64'd6000, 16'd2, 16'd0);
        send_pkt(64'd6000, 4, -1);
        drain(4);
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        n_checks++;
        if (status_state !== 2'd3) $display("FAIL flush_state: got %0d need 3", status_state); else n_pass++;
        tick();
        n_checks++;
        if (status_state !== 2'd0) $display("FAIL flush_idle: got %0d need 0", status_state); else n_pass++;
        gen_exp(0, 2, 2, 64'd6000, 1'b0);
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL flush_count: got %0d need %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL flush_beat[%0d]: got %h need %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_cfg_err();
        arm(64'd0, 16'd0, 16'd1);
        n_checks++;
        if (status_cfg_err !== 1'b1) $display("FAIL cfgerr_set: got %b need 1", status_cfg_err); else n_pass++;
        n_checks++;
        if (status_state !== 2'd0) $display("FAIL cfgerr_idle: got %0d need 0", status_state); else n_pass++;
        arm(64'd5000, 16'd2, 16'd1);
        n_checks++;
        if (status_cfg_err !== 1'b0) $display("FAIL cfgerr_clear: got %b need 0", status_cfg_err); else n_pass++;
        n_checks++;
        if (status_state !== 2'd1) $display("FAIL cfgerr_rearm: got %0d need 1", status_state); else n_pass++;
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        n_checks++;
        if (status_state !== 2'd0) $display("FAIL armed_stop: got %0d need 0", status_state); else n_pass++;
    endtask

    task automatic test_wrap();
        got_q.delete();
        arm(64'hFFFF_FFFF_FFFF_FFFA, 16'd4, 16'd3);
        send_pkt(64'hFFFF_FFFF_FFFF_FFF8, 16, -1);
        drain(12);
        gen_exp(2, 4, 3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL wrap_count: got %0d need %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL wrap_beat[%0d]: got %h need %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    initial begin
        rst               = 1'b1;
        cfg_start_time    = 64'd0;
        cfg_period_len    = 16'd0;
        cfg_num_periods   = 16'd0;
        cfg_arm           = 1'b0;
        cfg_stop          = 1'b0;
        s_axis_tdata      = 32'd0;
        s_axis_tlast      = 1'b0;
        s_axis_tvalid     = 1'b0;
        s_axis_ttimestamp = 64'd0;
        s_axis_thas_time  = 1'b0;
        s_axis_teob       = 1'b0;
        m_axis_tready     = 1'b1;

        test_reset();
        test_exact_start();
        test_late_start();
        test_backpressure();
        test_continuous_stop();
        test_flush();
        test_cfg_err();
        test_wrap();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
